// File: rtl/cache_miss_ctrl.sv
// Purpose : one-at-a-time CPU load/store sequencer for a 4-way set-associative data cache. It runs the
//           tag lookup, writes back a dirty victim, refills the line and commits the access.
// Latency : accept -> cpu_resp_valid is 3 cycles on a hit. A clean miss takes 5 + fill-accept wait + data wait.
//           A dirty miss adds 1 + write-buffer accept wait.
// Backpressure: cpu_req_ready is high only in IDLE. wb_req_valid and mem_rd_valid are held until their ready.
//           Fill data is taken from a single-cycle mem_rdata_valid pulse and is only looked at in REFILL_WAIT.
//
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   cpu_req_*                 CPU request (valid/ready, wr, addr, wdata)
//   cpu_resp_valid            one-cycle completion pulse
//   hit_en                    tag_ram hit vector, sampled in LOOKUP
//   victim_way, victim_dirty  LRU victim and its dirty bit, sampled in LOOKUP
//   req_addr/req_wr/req_wdata latched request towards tag_ram/data_ram
//   ram_access_en, lru_update single-cycle commit strobes
//   hit_en_r1, replace_en_r1  one-hot way selects, non-zero only in COMMIT
//   tag_we                    tag/valid write for the replaced way
//   refill_data               line captured from memory
//   wb_req_*                  victim write-back handshake
//   mem_rd_*, mem_rdata*      line-fill request and its returned data
//   hit_count, miss_count     wrapping performance counters
module cache_miss_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_WIDTH = 32,
    parameter int LINE_WIDTH = 128,
    parameter int WAY_NUM    = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  cpu_req_valid,
    output logic                  cpu_req_ready,
    input  logic                  cpu_req_wr,
    input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
    input  logic [WORD_WIDTH-1:0] cpu_req_wdata,
    output logic                  cpu_resp_valid,

    input  logic [WAY_NUM-1:0]    hit_en,
    input  logic [WAY_NUM-1:0]    victim_way,
    input  logic                  victim_dirty,

    output logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  req_wr,
    output logic [WORD_WIDTH-1:0] req_wdata,
    output logic                  ram_access_en,
    output logic [WAY_NUM-1:0]    hit_en_r1,
    output logic [WAY_NUM-1:0]    replace_en_r1,
    output logic [LINE_WIDTH-1:0] refill_data,
    output logic                  tag_we,
    output logic                  lru_update,

    output logic                  wb_req_valid,
    input  logic                  wb_req_ready,

    output logic                  mem_rd_valid,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic                  mem_rd_ready,
    input  logic                  mem_rdata_valid,
    input  logic [LINE_WIDTH-1:0] mem_rdata,

    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count
);

    // Byte-offset bits within one cacheline (4 for a 16-byte line).
    localparam int                   OFFSET_BITS = $clog2(LINE_WIDTH / 8);
    localparam logic [WAY_NUM-1:0]   WAY0        = WAY_NUM'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WRITEBACK,
        S_REFILL_REQ,
        S_REFILL_WAIT,
        S_COMMIT,
        S_RESP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WAY_NUM-1:0] hit_way_q;
    logic [WAY_NUM-1:0] victim_way_q;
    logic               miss_q;

    // Isolate the lowest set bit. A multi-hot vector from tag_ram or LRU
    // would otherwise select several ways at commit.
    function automatic logic [WAY_NUM-1:0] lowest_one(input logic [WAY_NUM-1:0] v);
        return v & (~v + WAY0);
    endfunction

    logic               lookup_hit;
    logic [WAY_NUM-1:0] lookup_hit_way;
    logic [WAY_NUM-1:0] lookup_victim_way;

    assign lookup_hit        = |hit_en;
    assign lookup_hit_way    = lowest_one(hit_en);
    // An all-zero victim from the LRU still has to replace something.
    // In that case fall back to way 0.
    assign lookup_victim_way = (victim_way == '0) ? WAY0 : lowest_one(victim_way);

    // Fills are always line aligned.
    assign mem_rd_addr = {req_addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and per-state outputs. The way selects and the RAM
    // strobes are only non-zero in COMMIT. This keeps data_ram untouched
    // while a miss is still in progress.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt      = state;
        cpu_req_ready  = 1'b0;
        cpu_resp_valid = 1'b0;
        wb_req_valid   = 1'b0;
        mem_rd_valid   = 1'b0;
        ram_access_en  = 1'b0;
        lru_update     = 1'b0;
        tag_we         = 1'b0;
        hit_en_r1      = '0;
        replace_en_r1  = '0;

        case (state)
            S_IDLE: begin
                cpu_req_ready = 1'b1;
                if (cpu_req_valid) begin
                    state_nxt = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (lookup_hit) begin
                    state_nxt = S_COMMIT;
                end else if (victim_dirty) begin
                    state_nxt = S_WRITEBACK;
                end else begin
                    state_nxt = S_REFILL_REQ;
                end
            end
            S_WRITEBACK: begin
                wb_req_valid = 1'b1;
                if (wb_req_ready) begin
                    state_nxt = S_REFILL_REQ;
                end
            end
            S_REFILL_REQ: begin
                mem_rd_valid = 1'b1;
                if (mem_rd_ready) begin
                    state_nxt = S_REFILL_WAIT;
                end
            end
            S_REFILL_WAIT: begin
                if (mem_rdata_valid) begin
                    state_nxt = S_COMMIT;
                end
            end
            S_COMMIT: begin
                ram_access_en = 1'b1;
                lru_update    = 1'b1;
                if (miss_q) begin
                    replace_en_r1 = victim_way_q;
                    tag_we        = 1'b1;
                end else begin
                    hit_en_r1 = hit_way_q;
                end
                state_nxt = S_RESP;
            end
            S_RESP: begin
                cpu_resp_valid = 1'b1;
                state_nxt      = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch: captured on accept, then held for the whole access.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_addr  <= '0;
            req_wr    <= 1'b0;
            req_wdata <= '0;
        end else if (state == S_IDLE && cpu_req_valid) begin
            req_addr  <= cpu_req_addr;
            req_wr    <= cpu_req_wr;
            req_wdata <= cpu_req_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Lookup result: exactly one of hit_way_q / victim_way_q is non-zero.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_way_q    <= '0;
            victim_way_q <= '0;
            miss_q       <= 1'b0;
        end else if (state == S_LOOKUP) begin
            miss_q <= ~lookup_hit;
            if (lookup_hit) begin
                hit_way_q    <= lookup_hit_way;
                victim_way_q <= '0;
            end else begin
                hit_way_q    <= '0;
                victim_way_q <= lookup_victim_way;
            end
        end
    end

    // ------------------------------------------------------------------
    // Refill capture. Fill data seen in any other state is a late beat of
    // an aborted fill, or a stray beat, so it is dropped.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refill_data <= '0;
        end else if (state == S_REFILL_WAIT && mem_rdata_valid) begin
            refill_data <= mem_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Performance counters. They advance once per completed access, in
    // COMMIT, so an access aborted by reset is never counted.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == S_COMMIT) begin
            if (miss_q) begin
                miss_count <= miss_count + CNT_ONE;
            end else begin
                hit_count <= hit_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
module tb_cache_miss_ctrl;

    localparam int LIMIT = 64;

    typedef logic [127:0] v_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_req_valid, cpu_req_ready, cpu_req_wr;
    logic [31:0]  cpu_req_addr, cpu_req_wdata;
    logic         cpu_resp_valid;
    logic [3:0]   hit_en, victim_way;
    logic         victim_dirty;
    logic [31:0]  req_addr;
    logic         req_wr;
    logic [31:0]  req_wdata;
    logic         ram_access_en;
    logic [3:0]   hit_en_r1, replace_en_r1;
    logic [127:0] refill_data;
    logic         tag_we, lru_update;
    logic         wb_req_valid, wb_req_ready;
    logic         mem_rd_valid, mem_rd_ready;
    logic [31:0]  mem_rd_addr;
    logic         mem_rdata_valid;
    logic [127:0] mem_rdata;
    logic [31:0]  hit_count, miss_count;

    cache_miss_ctrl dut (
        .clk(clk), .rst(rst),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_wr(cpu_req_wr), .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
        .cpu_resp_valid(cpu_resp_valid),
        .hit_en(hit_en), .victim_way(victim_way), .victim_dirty(victim_dirty),
        .req_addr(req_addr), .req_wr(req_wr), .req_wdata(req_wdata),
        .ram_access_en(ram_access_en), .hit_en_r1(hit_en_r1), .replace_en_r1(replace_en_r1),
        .refill_data(refill_data), .tag_we(tag_we), .lru_update(lru_update),
        .wb_req_valid(wb_req_valid), .wb_req_ready(wb_req_ready),
        .mem_rd_valid(mem_rd_valid), .mem_rd_addr(mem_rd_addr), .mem_rd_ready(mem_rd_ready),
        .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input v_t act, input v_t exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name, input string what);
        n_chk++;
        $display("FAIL %s: %s", name, what);
    endtask

    task automatic timeout(input string name);
        fail_now(name, "no response within cycle budget, expected a handshake");
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0]  addr;
        logic         wr;
        logic [31:0]  wdata;
        bit           hit;
        logic [3:0]   hit_way;
        logic [3:0]   repl_way;
        logic [127:0] line;
        logic [31:0]  hits;
        logic [31:0]  misses;
        int           lat;
        int           wb_cyc;
        int           rd_cyc;
    } exp_t;

    exp_t         sb[$];
    logic [31:0]  m_hits = 0, m_misses = 0;
    logic [127:0] m_line = 0;

    // Lowest numbered way present in v. An empty vector selects way 0.
    function automatic logic [3:0] first_way(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return 4'b0001 << i;
        return 4'b0001;
    endfunction

    // ---------------- monitor ----------------
    bit          in_flight = 0;
    int unsigned acc_cyc = 0;
    int          wb_cnt = 0, rd_cnt = 0, commit_cnt = 0, leak_cnt = 0;
    bit          bad_ready = 0, bad_order = 0, bad_addr = 0;
    exp_t        mon_e;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            in_flight = 0;
        end else begin
            if (!ram_access_en && (hit_en_r1 != 0 || replace_en_r1 != 0 || tag_we || lru_update))
                leak_cnt++;
            if (in_flight) begin
                if (cpu_req_ready) bad_ready = 1;
                if (wb_req_valid) begin
                    wb_cnt++;
                    if (rd_cnt > 0) bad_order = 1;
                end
                if (mem_rd_valid) begin
                    rd_cnt++;
                    if (wb_req_valid) bad_order = 1;
                    if (sb.size() > 0) begin
                        mon_e = sb[0];
                        if (mem_rd_addr !== {mon_e.addr[31:4], 4'b0000}) bad_addr = 1;
                    end
                end
            end
            if (ram_access_en) begin
                commit_cnt++;
                if (sb.size() == 0) fail_now("unexpected_commit", "ram_access_en=1 with no access outstanding");
                else begin
                    mon_e = sb[0];
                    chk("commit_hit_en_r1", v_t'(hit_en_r1), v_t'(mon_e.hit_way));
                    chk("commit_replace_en_r1", v_t'(replace_en_r1), v_t'(mon_e.repl_way));
                    chk("commit_tag_we", v_t'(tag_we), v_t'(!mon_e.hit));
                    chk("commit_lru_update", v_t'(lru_update), v_t'(1));
                    chk("commit_req_addr", v_t'(req_addr), v_t'(mon_e.addr));
                    chk("commit_req_wr", v_t'(req_wr), v_t'(mon_e.wr));
                    chk("commit_req_wdata", v_t'(req_wdata), v_t'(mon_e.wdata));
                    chk("commit_refill_data", refill_data, mon_e.line);
                end
            end
            if (cpu_resp_valid) begin
                if (sb.size() == 0) fail_now("unexpected_resp", "cpu_resp_valid=1 with no access outstanding");
                else begin
                    mon_e = sb.pop_front();
                    chk("resp_latency", v_t'(cyc - acc_cyc), v_t'(mon_e.lat));
                    chk("resp_hit_count", v_t'(hit_count), v_t'(mon_e.hits));
                    chk("resp_miss_count", v_t'(miss_count), v_t'(mon_e.misses));
                    chk("resp_wb_valid_cycles", v_t'(wb_cnt), v_t'(mon_e.wb_cyc));
                    chk("resp_mem_rd_valid_cycles", v_t'(rd_cnt), v_t'(mon_e.rd_cyc));
                    chk("resp_commit_count", v_t'(commit_cnt), v_t'(1));
                    chk("resp_ready_low_while_busy", v_t'(bad_ready), v_t'(0));
                    chk("resp_wb_before_fill", v_t'(bad_order), v_t'(0));
                    chk("resp_mem_rd_addr_stable", v_t'(bad_addr), v_t'(0));
                end
                in_flight = 0;
            end
            if (cpu_req_valid && cpu_req_ready) begin
                in_flight = 1; acc_cyc = cyc;
                wb_cnt = 0; rd_cnt = 0; commit_cnt = 0;
                bad_ready = 0; bad_order = 0; bad_addr = 0;
            end
        end
    end

    // ---------------- driver ----------------
    function automatic logic probe(input int which);
        case (which)
            0:       return wb_req_valid;
            1:       return mem_rd_valid;
            default: return cpu_resp_valid;
        endcase
    endfunction

    task automatic wait_high(input int which, input string name);
        int t = 0;
        while (!probe(which) && t < LIMIT) begin
            @(posedge clk); #1; t++;
        end
        if (t >= LIMIT) timeout(name);
    endtask

    task automatic cycle;
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                         input logic [3:0] hit, input logic [3:0] victim, input logic dirty,
                         output bit ok);
        int t = 0;
        cpu_req_addr = addr; cpu_req_wr = wr; cpu_req_wdata = wdata;
        hit_en = hit; victim_way = victim; victim_dirty = dirty;
        cpu_req_valid = 1;
        ok = 0;
        while (!ok && t < LIMIT) begin
            @(negedge clk); ok = cpu_req_ready;
            @(posedge clk); #1; t++;
        end
        cpu_req_valid = 0;
        if (!ok) timeout("cpu_req_ready");
    endtask

    task automatic run_txn(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                           input logic [3:0] hit, input logic [3:0] victim, input logic dirty,
                           input int wbw, input int rdw, input int dw,
                           input logic [127:0] line, input bit stray);
        exp_t e;
        bit   ok;
        e.addr = addr; e.wr = wr; e.wdata = wdata;
        e.hit      = (hit != 0);
        e.hit_way  = e.hit ? first_way(hit) : 4'b0000;
        e.repl_way = e.hit ? 4'b0000 : first_way(victim);
        if (!e.hit) m_line = line;
        e.line = m_line;
        if (e.hit) m_hits++; else m_misses++;
        e.hits = m_hits; e.misses = m_misses;
        e.wb_cyc = (!e.hit && dirty) ? wbw + 1 : 0;
        e.rd_cyc = e.hit ? 0 : rdw + 1;
        e.lat    = e.hit ? 3 : 5 + rdw + dw + ((e.wb_cyc != 0) ? 1 + wbw : 0);
        sb.push_back(e);

        issue(addr, wr, wdata, hit, victim, dirty, ok);
        if (!ok) begin
            void'(sb.pop_back());
            return;
        end
        // LOOKUP cycle: a stray fill beat here must not be captured.
        if (stray) begin
            mem_rdata_valid = 1; mem_rdata = ~line;
            cycle();
            mem_rdata_valid = 0;
        end
        if (!e.hit) begin
            if (dirty) begin
                wait_high(0, "wb_req_valid");
                repeat (wbw) cycle();
                wb_req_ready = 1; cycle(); wb_req_ready = 0;
            end
            wait_high(1, "mem_rd_valid");
            if (stray && rdw > 0) begin
                mem_rdata_valid = 1; mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            end
            repeat (rdw) begin
                cycle();
                mem_rdata_valid = 0;
            end
            mem_rd_ready = 1; cycle(); mem_rd_ready = 0;
            repeat (dw) cycle();
            mem_rdata_valid = 1; mem_rdata = line;
            cycle();
            mem_rdata_valid = 0; mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        end
        wait_high(2, "cpu_resp_valid");
    endtask

    task automatic rand_txn;
        logic [3:0] h;
        h = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
        run_txn($urandom, 1'($urandom_range(0, 1)), $urandom, h, 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 4),
                $urandom_range(0, 4), {$urandom, $urandom, $urandom, $urandom},
                $urandom_range(0, 3) == 0);
        repeat ($urandom_range(0, 2)) cycle();
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_cpu_req_ready"}, v_t'(cpu_req_ready), v_t'(1));
        chk({tag, "_cpu_resp_valid"}, v_t'(cpu_resp_valid), v_t'(0));
        chk({tag, "_ram_access_en"}, v_t'(ram_access_en), v_t'(0));
        chk({tag, "_tag_we"}, v_t'(tag_we), v_t'(0));
        chk({tag, "_lru_update"}, v_t'(lru_update), v_t'(0));
        chk({tag, "_hit_en_r1"}, v_t'(hit_en_r1), v_t'(0));
        chk({tag, "_replace_en_r1"}, v_t'(replace_en_r1), v_t'(0));
        chk({tag, "_wb_req_valid"}, v_t'(wb_req_valid), v_t'(0));
        chk({tag, "_mem_rd_valid"}, v_t'(mem_rd_valid), v_t'(0));
        chk({tag, "_req_addr"}, v_t'(req_addr), v_t'(0));
        chk({tag, "_refill_data"}, refill_data, v_t'(0));
        chk({tag, "_hit_count"}, v_t'(hit_count), v_t'(0));
        chk({tag, "_miss_count"}, v_t'(miss_count), v_t'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst = 1;
        cpu_req_valid = 0; cpu_req_wr = 0; cpu_req_addr = 0; cpu_req_wdata = 0;
        hit_en = 0; victim_way = 0; victim_dirty = 0;
        wb_req_ready = 0; mem_rd_ready = 0; mem_rdata_valid = 0; mem_rdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        @(posedge clk); #1;
        rst = 0;
        cycle();

        // Directed cases.
        run_txn(32'h0000_0100, 0, 32'h0, 4'b0010, 4'b1000, 0, 0, 0, 0, 128'h0, 0);
        run_txn(32'h0000_010C, 0, 32'h0, 4'b0000, 4'b0100, 0, 0, 0, 4,
                128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 0);
        run_txn(32'h0000_2208, 1, 32'hDEAD_BEEF, 4'b0000, 4'b0001, 1, 2, 0, 1,
                128'hAAAA_5555_AAAA_5555_AAAA_5555_AAAA_5555, 1);
        run_txn(32'h0000_3004, 0, 32'h0, 4'b0000, 4'b1000, 0, 0, 5, 0,
                128'h1111_2222_3333_4444_5555_6666_7777_8888, 1);
        run_txn(32'h0000_4010, 0, 32'h0, 4'b0110, 4'b0001, 1, 0, 0, 0, 128'h0, 1);
        run_txn(32'h0000_5020, 1, 32'h1234_5678, 4'b0000, 4'b0000, 0, 0, 1, 2,
                128'hCAFE_F00D_CAFE_F00D_CAFE_F00D_CAFE_F00D, 0);

        for (int i = 0; i < 40; i++) rand_txn();

        // Reset while waiting for fill data; the late beat must be ignored.
        issue(32'h0000_6040, 0, 32'h0, 4'b0000, 4'b0100, 0, ok);
        if (ok) begin
            wait_high(1, "mem_rd_valid");
            mem_rd_ready = 1; cycle(); mem_rd_ready = 0;
            repeat (2) cycle();
        end
        rst = 1;
        #2;
        chk("async_reset_cpu_req_ready", v_t'(cpu_req_ready), v_t'(1));
        repeat (2) cycle();
        rst = 0;
        m_hits = 0; m_misses = 0; m_line = 0;
        mem_rdata_valid = 1; mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        cycle();
        mem_rdata_valid = 0;
        repeat (3) cycle();
        @(negedge clk);
        check_idle("post_reset");
        cycle();

        for (int i = 0; i < 6; i++) rand_txn();

        repeat (5) cycle();
        chk("quiet_outside_commit", v_t'(leak_cnt), v_t'(0));
        chk("scoreboard_drained", v_t'(sb.size()), v_t'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
